// File: rtl/lab3_pkg.sv
// Shared types and default constants for the lab3 serial stream transmitter.
package lab3_pkg;

  // Transmitter phases: waiting, preamble, payload, inter-frame gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Default preamble: two zero bits, sent MSB first.
  localparam int unsigned PRE_LEN_DEF  = 2;
  localparam logic [1:0]  PRE_BITS_DEF = 2'b00;

endpackage : lab3_pkg

// File: rtl/lab3_shift_reg.sv
// Payload shifter: parallel load, shift right, exposes the LSB.
module lab3_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         lsb
);

  logic [W-1:0] q;

  // Load has priority over shift; synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q >> 1;
    end
  end

  assign lsb = q[0];

endmodule : lab3_shift_reg

// File: rtl/lab3_serial_stream_tx.sv
// Serial frame transmitter: preamble (MSB first), payload (LSB first), idle gap.
module lab3_serial_stream_tx
  import lab3_pkg::*;
#(
  parameter int unsigned         DATA_W     = 8,
  parameter int unsigned         PRE_LEN    = PRE_LEN_DEF,
  parameter logic [PRE_LEN-1:0]  PRE_BITS   = PRE_LEN'(PRE_BITS_DEF),
  parameter int unsigned         GAP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        length,
  output logic              ready,
  output logic              x,
  output logic              frame,
  output logic              done
);

  // Counter covers the longer of preamble and payload so it never wraps mid-frame.
  localparam int unsigned CNT_MAX = (DATA_W > PRE_LEN) ? DATA_W : PRE_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned GAP_W   = 4;

  // Preamble left-aligned into a 4-bit field so bit 3 is always the next bit out.
  localparam logic [3:0] PRE_ALIGN = 4'(PRE_BITS) << (4 - PRE_LEN);

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [CNT_W-1:0]   len_q, len_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [3:0]         pre_q, pre_n;
  logic               x_n, frame_n, ready_n, done_n;
  logic               sr_load, sr_shift, sr_lsb;
  logic [CNT_W-1:0]   len_clamp_c;

  // Out-of-range length (0 or wider than the payload register) means full width.
  always_comb begin
    if (length == 4'd0 || 32'(length) > DATA_W) begin
      len_clamp_c = CNT_W'(DATA_W);
    end else begin
      len_clamp_c = CNT_W'(length);
    end
  end

  lab3_shift_reg #(
    .W (DATA_W)
  ) u_shift (
    .clock (clock),
    .reset (reset),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (data),
    .lsb   (sr_lsb)
  );

  // State, counters and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      pre_q   <= '0;
      x       <= 1'b1;
      frame   <= 1'b0;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      len_q   <= len_n;
      gap_q   <= gap_n;
      pre_q   <= pre_n;
      x       <= x_n;
      frame   <= frame_n;
      ready   <= ready_n;
      done    <= done_n;
    end
  end

  // Next state and next registered outputs; cnt counts bits already placed on x.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    len_n    = len_q;
    gap_n    = gap_q;
    pre_n    = pre_q;
    x_n      = 1'b1;
    frame_n  = 1'b0;
    ready_n  = 1'b0;
    done_n   = 1'b0;
    sr_load  = 1'b0;
    sr_shift = 1'b0;

    case (state_q)
      IDLE: begin
        ready_n = 1'b1;
        if (load) begin
          state_n = PRE;
          len_n   = len_clamp_c;
          sr_load = 1'b1;
          x_n     = PRE_ALIGN[3];
          pre_n   = PRE_ALIGN << 1;
          cnt_n   = CNT_W'(1);
          frame_n = 1'b1;
          ready_n = 1'b0;
        end
      end

      PRE: begin
        frame_n = 1'b1;
        if (cnt_q == CNT_W'(PRE_LEN)) begin
          state_n  = DATA;
          x_n      = sr_lsb;
          sr_shift = 1'b1;
          cnt_n    = CNT_W'(1);
        end else begin
          x_n   = pre_q[3];
          pre_n = pre_q << 1;
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == len_q) begin
          state_n = GAP;
          done_n  = 1'b1;
          gap_n   = GAP_W'(1);
          cnt_n   = '0;
        end else begin
          x_n      = sr_lsb;
          sr_shift = 1'b1;
          frame_n  = 1'b1;
          cnt_n    = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES)) begin
          state_n = IDLE;
          ready_n = 1'b1;
          gap_n   = '0;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

endmodule : lab3_serial_stream_tx
